// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Owns the program-counter register that sits
// directly after the next-PC mux. Issues single-outstanding requests to
// instruction memory and buffers returned words in a 2-entry FIFO toward
// decode. A redirect from execute (pcSrc) flushes buffered and in-flight
// instructions.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   : a word returning into an empty FIFO is presented to decode in
//               the same cycle (combinational bypass), saving one cycle.
//   undefined : decode outputs come from the FIFO only (fully registered).
//
// Parameters
//   RESET_PC    PC value loaded on reset.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   pcNext      next PC from the next-PC mux (target or pcPlusFour)
//   pcSrc       redirect / flush strobe from execute
//   pc          current fetch PC register
//   pcPlusFour  pc + 4 (mod 2^32), back to the next-PC mux
//   imemReq     instruction-memory request
//   imemAddr    request address (always equal to pc)
//   imemGnt     memory accepted the request this cycle
//   imemRvalid  read data valid
//   imemRdata   read data
//   instValid   instruction available to decode
//   instData    instruction word
//   instPc      address of instData
//   instReady   decode accepts this cycle
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pcNext,
    input  logic        pcSrc,
    output logic [31:0] pc,
    output logic [31:0] pcPlusFour,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic        instValid,
    output logic [31:0] instData,
    output logic [31:0] instPc,
    input  logic        instReady
);

    typedef enum logic [1:0] {
        S_FETCH,  // requesting when the FIFO has room
        S_WAIT,   // request granted, waiting for the response
        S_HOLD,   // FIFO full, waiting for decode to pop
        S_DROP    // response outstanding for a squashed address
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;

    logic [31:0] r_fifo_pc   [2];
    logic [31:0] r_fifo_data [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_req;
    logic        w_gnt;
    logic        w_resp;
    logic        w_bypass;
    logic        w_push;
    logic        w_pop;

    // Request only from FETCH with room in the FIFO; forced low in reset.
    assign w_req  = rst_n && (r_state == S_FETCH) && (r_count != 2'd2);
    assign w_gnt  = w_req && imemGnt;
    // A response that belongs to the current (non-squashed) stream.
    assign w_resp = (r_state == S_WAIT) && imemRvalid && !pcSrc;

`ifdef FETCH_BYPASS_EN
    assign w_bypass  = w_resp && (r_count == 2'd0);
    assign instValid = (r_count != 2'd0) || w_bypass;
    assign instData  = w_bypass ? imemRdata : r_fifo_data[r_rd_ptr];
    assign instPc    = w_bypass ? r_req_pc  : r_fifo_pc[r_rd_ptr];
`else
    assign w_bypass  = 1'b0;
    assign instValid = (r_count != 2'd0);
    assign instData  = r_fifo_data[r_rd_ptr];
    assign instPc    = r_fifo_pc[r_rd_ptr];
`endif

    // A bypassed word consumed by decode this cycle never enters the FIFO.
    assign w_push = w_resp && !(w_bypass && instReady);
    // A pop in the flush cycle is meaningless: the FIFO is being cleared.
    assign w_pop  = (r_count != 2'd0) && instReady && !pcSrc;

    assign pc         = r_pc;
    assign pcPlusFour = r_pc + 32'd4;
    assign imemAddr   = r_pc;
    assign imemReq    = w_req;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statement leaves a value held (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (pcSrc) begin
                    // A grant in the redirect cycle was for the old pc.
                    w_state_next = w_gnt ? S_DROP : S_FETCH;
                end else if (r_count == 2'd2) begin
                    w_state_next = S_HOLD;
                end else if (w_gnt) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imemRvalid) begin
                    w_state_next = S_FETCH;
                end else if (pcSrc) begin
                    w_state_next = S_DROP;
                end
            end
            S_HOLD: begin
                if (pcSrc || w_pop || (r_count != 2'd2)) begin
                    w_state_next = S_FETCH;
                end
            end
            S_DROP: begin
                if (imemRvalid) begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            r_state <= w_state_next;
            if (pcSrc || w_gnt) begin
                r_pc <= pcNext;
            end
            if (w_gnt) begin
                r_req_pc <= r_pc;
            end
            if (pcSrc) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    // NOTE: FIFO storage is deliberately not reset; r_count qualifies every
    // read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_req_pc;
            r_fifo_data[r_wr_ptr] <= imemRdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit (RESET_PC = 0x100). The bench models
// the next-PC mux (pcNext = pcSrc ? target : pcPlusFour) and an instruction
// memory that returns word = address a configurable number of cycles after
// grant. Directed scenarios cover reset, streaming, hold, and the three
// redirect cases; a randomized run is checked against a program-order model
// (expected fetch PC and expected next delivered PC).
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef FETCH_BYPASS_EN
    localparam int EXP_LAT = 1;
    localparam int EXP_DEL = 6;
`else
    localparam int EXP_LAT = 2;
    localparam int EXP_DEL = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pcNext;
    logic        pcSrc;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] pcPlusFour;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        instValid;
    logic [31:0] instData;
    logic [31:0] instPc;
    logic        instReady;

    assign pcNext = pcSrc ? target : pcPlusFour;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pcNext     (pcNext),
        .pcSrc      (pcSrc),
        .pc         (pc),
        .pcPlusFour (pcPlusFour),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemGnt    (imemGnt),
        .imemRvalid (imemRvalid),
        .imemRdata  (imemRdata),
        .instValid  (instValid),
        .instData   (instData),
        .instPc     (instPc),
        .instReady  (instReady)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model state
    bit          mem_pending = 1'b0;
    logic [31:0] mem_addr    = '0;
    int          mem_cnt     = 0;
    int          mem_lat     = 1;

    // Per-cycle observations
    logic        obs_req, obs_valid, obs_gnt;
    logic [31:0] obs_addr, obs_p4, obs_pc, obs_data, obs_dut_pc;
    bit          pend_at_obs;
    int          cyc;
    int          vcyc_first;
    logic [31:0] gq[$];
    int          gcyc[$];
    logic [31:0] dq_pc[$];
    logic [31:0] dq_data[$];

    task automatic clear_obs();
        gq.delete();
        gcyc.delete();
        dq_pc.delete();
        dq_data.delete();
        vcyc_first = -1;
        cyc = 0;
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic cycle(input bit src, input logic [31:0] tgt, input bit rdy, input bit gnt_en);
        pcSrc      = src;
        target     = tgt;
        instReady  = rdy;
        imemRvalid = mem_pending && (mem_cnt == 0);
        imemRdata  = imemRvalid ? mem_addr : 32'hDEAD_BEEF;
        #1;
        imemGnt    = gnt_en && (imemReq === 1'b1);
        #1;
        obs_req     = imemReq;
        obs_gnt     = imemGnt;
        obs_addr    = imemAddr;
        obs_p4      = pcPlusFour;
        obs_dut_pc  = pc;
        obs_valid   = instValid;
        obs_pc      = instPc;
        obs_data    = instData;
        pend_at_obs = mem_pending;
        if (obs_gnt) begin
            gq.push_back(obs_addr);
            gcyc.push_back(cyc);
        end
        if (obs_valid === 1'b1 && vcyc_first < 0) vcyc_first = cyc;
        if (obs_valid === 1'b1 && rdy && !src) begin
            dq_pc.push_back(obs_pc);
            dq_data.push_back(obs_data);
        end
        @(posedge clk);
        if (!rst_n) begin
            mem_pending = 1'b0;
        end else begin
            if (imemRvalid) mem_pending = 1'b0;
            else if (mem_pending) mem_cnt--;
            if (obs_gnt) begin
                mem_pending = 1'b1;
                mem_addr    = obs_addr;
                mem_cnt     = mem_lat - 1;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        clear_obs();
    endtask

    task automatic wait_delivery();
        for (int k = 0; k < 30 && dq_pc.size() == 0; k++) cycle(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (dq_pc.size() == 0) begin
            $display("FAIL delivery_timeout: got none within 30 cycles, expected one");
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (obs_req !== 1'b0) begin $display("FAIL reset_req: got %b expected 0", obs_req); n_fail++; end
        n_checks++;
        if (obs_valid !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", obs_valid); n_fail++; end
        n_checks++;
        if (obs_dut_pc !== RST_PC) begin $display("FAIL reset_pc: got %h expected %h", obs_dut_pc, RST_PC); n_fail++; end
        n_checks++;
        if (obs_addr !== RST_PC) begin $display("FAIL reset_addr: got %h expected %h", obs_addr, RST_PC); n_fail++; end
        n_checks++;
        if (obs_p4 !== RST_PC + 32'd4) begin $display("FAIL reset_p4: got %h expected %h", obs_p4, RST_PC + 32'd4); n_fail++; end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] exp_a;
        logic [31:0] got;
        do_reset();
        mem_lat = 1;
        repeat (12) cycle(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_a = RST_PC + 32'(4 * i);
            got = (i < gq.size()) ? gq[i] : 'x;
            n_checks++;
            if (got !== exp_a) begin $display("FAIL stream_addr%0d: got %h expected %h", i, got, exp_a); n_fail++; end
            got = (i < dq_pc.size()) ? dq_pc[i] : 'x;
            n_checks++;
            if (got !== exp_a) begin $display("FAIL stream_instpc%0d: got %h expected %h", i, got, exp_a); n_fail++; end
            got = (i < dq_data.size()) ? dq_data[i] : 'x;
            n_checks++;
            if (got !== exp_a) begin $display("FAIL stream_instdata%0d: got %h expected %h", i, got, exp_a); n_fail++; end
        end
        n_checks++;
        if (gcyc.size() == 0 || vcyc_first - gcyc[0] != EXP_LAT) begin
            $display("FAIL stream_latency: got %0d expected %0d", (gcyc.size() == 0) ? -1 : vcyc_first - gcyc[0], EXP_LAT);
            n_fail++;
        end
        n_checks++;
        if (dq_pc.size() != EXP_DEL) begin
            $display("FAIL stream_throughput: got %0d deliveries expected %0d", dq_pc.size(), EXP_DEL);
            n_fail++;
        end
    endtask

    task automatic test_hold();
        bit found;
        do_reset();
        mem_lat = 1;
        repeat (8) cycle(1'b0, '0, 1'b0, 1'b1);
        n_checks++;
        if (gq.size() != 2) begin $display("FAIL hold_grants: got %0d expected 2", gq.size()); n_fail++; end
        n_checks++;
        if (obs_req !== 1'b0) begin $display("FAIL hold_req: got %b expected 0", obs_req); n_fail++; end
        n_checks++;
        if (obs_valid !== 1'b1 || obs_pc !== RST_PC) begin
            $display("FAIL hold_head: got valid=%b pc=%h expected valid=1 pc=%h", obs_valid, obs_pc, RST_PC);
            n_fail++;
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (dq_pc.size() != 1 || dq_pc[0] !== RST_PC) begin
            $display("FAIL hold_pop: got %0d pops expected one of %h", dq_pc.size(), RST_PC);
            n_fail++;
        end
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            cycle(1'b0, '0, 1'b0, 1'b0);
            if (obs_req === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found || obs_addr !== RST_PC + 32'h8) begin
            $display("FAIL hold_rereq: got req=%b addr=%h expected req=1 addr=%h", found, obs_addr, RST_PC + 32'h8);
            n_fail++;
        end
        n_checks++;
        if (obs_valid !== 1'b1 || obs_pc !== RST_PC + 32'h4) begin
            $display("FAIL hold_second: got valid=%b pc=%h expected valid=1 pc=%h", obs_valid, obs_pc, RST_PC + 32'h4);
            n_fail++;
        end
    endtask

    task automatic test_flush_wait();
        do_reset();
        mem_lat = 3;
        repeat (5) cycle(1'b0, '0, 1'b0, 1'b1);
        n_checks++;
        if (obs_valid !== 1'b1 || gq.size() != 2) begin
            $display("FAIL fw_setup: got valid=%b grants=%0d expected valid=1 grants=2", obs_valid, gq.size());
            n_fail++;
        end
        cycle(1'b1, 32'h400, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (obs_valid !== 1'b0) begin $display("FAIL fw_valid: got %b expected 0", obs_valid); n_fail++; end
        n_checks++;
        if (obs_addr !== 32'h400) begin $display("FAIL fw_addr: got %h expected 00000400", obs_addr); n_fail++; end
        wait_delivery();
        n_checks++;
        if (dq_pc.size() > 0 && (dq_pc[0] !== 32'h400 || dq_data[0] !== 32'h400)) begin
            $display("FAIL fw_first: got pc=%h data=%h expected 00000400", dq_pc[0], dq_data[0]);
            n_fail++;
        end
    endtask

    task automatic test_flush_grant();
        do_reset();
        mem_lat = 2;
        cycle(1'b1, 32'h800, 1'b1, 1'b1);
        n_checks++;
        if (obs_gnt !== 1'b1) begin $display("FAIL fg_grant: got %b expected 1", obs_gnt); n_fail++; end
        cycle(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b0) begin
            $display("FAIL fg_drop: got valid=%b req=%b expected 0 0", obs_valid, obs_req);
            n_fail++;
        end
        wait_delivery();
        n_checks++;
        if (gq.size() < 2 || gq[1] !== 32'h800) begin
            $display("FAIL fg_reqaddr: got %h expected 00000800", (gq.size() < 2) ? 32'hx : gq[1]);
            n_fail++;
        end
        n_checks++;
        if (dq_pc.size() > 0 && dq_pc[0] !== 32'h800) begin
            $display("FAIL fg_first: got %h expected 00000800", dq_pc[0]);
            n_fail++;
        end
    endtask

    task automatic test_flush_rvalid();
        do_reset();
        mem_lat = 1;
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, 32'hC00, 1'b1, 1'b1);
        n_checks++;
        if (dq_pc.size() != 0) begin $display("FAIL fr_nodeliver: got %0d expected 0", dq_pc.size()); n_fail++; end
        cycle(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'hC00 || obs_valid !== 1'b0) begin
            $display("FAIL fr_next: got req=%b addr=%h valid=%b expected 1 00000c00 0", obs_req, obs_addr, obs_valid);
            n_fail++;
        end
        wait_delivery();
        n_checks++;
        if (dq_pc.size() > 0 && dq_pc[0] !== 32'hC00) begin
            $display("FAIL fr_first: got %h expected 00000c00", dq_pc[0]);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_lat = 1;
        repeat (5) cycle(1'b0, '0, 1'b1, 1'b1);
        rst_n = 1'b0;
        cycle(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (obs_req !== 1'b0) begin $display("FAIL rm_req: got %b expected 0", obs_req); n_fail++; end
        rst_n = 1'b1;
        clear_obs();
        cycle(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (obs_valid !== 1'b0 || obs_addr !== RST_PC || obs_req !== 1'b1) begin
            $display("FAIL rm_restart: got valid=%b addr=%h req=%b expected 0 %h 1", obs_valid, obs_addr, obs_req, RST_PC);
            n_fail++;
        end
        wait_delivery();
        n_checks++;
        if (dq_pc.size() > 0 && dq_pc[0] !== RST_PC) begin
            $display("FAIL rm_first: got %h expected %h", dq_pc[0], RST_PC);
            n_fail++;
        end
    endtask

    task automatic test_random();
        logic [31:0] m_pc;
        logic [31:0] m_deliv;
        logic [31:0] tgt;
        bit          src, rdy, g, prev_src;
        int          n_del;
        do_reset();
        m_pc     = RST_PC;
        m_deliv  = RST_PC;
        prev_src = 1'b0;
        n_del    = 0;
        for (int i = 0; i < 600; i++) begin
            if (!mem_pending) mem_lat = $urandom_range(1, 3);
            src = ($urandom_range(0, 11) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF8;
            rdy = ($urandom_range(0, 3) != 0);
            g   = ($urandom_range(0, 2) != 0);
            cycle(src, tgt, rdy, g);
            n_checks++;
            if (obs_addr !== m_pc || obs_p4 !== m_pc + 32'd4) begin
                $display("FAIL rnd_pc@%0d: got addr=%h p4=%h expected %h %h", i, obs_addr, obs_p4, m_pc, m_pc + 32'd4);
                n_fail++;
            end
            n_checks++;
            if (obs_req === 1'b1 && pend_at_obs) begin
                $display("FAIL rnd_outstanding@%0d: got req=1 expected 0 with response pending", i);
                n_fail++;
            end
            if (prev_src) begin
                n_checks++;
                if (obs_valid !== 1'b0) begin $display("FAIL rnd_flush@%0d: got valid=%b expected 0", i, obs_valid); n_fail++; end
            end
            if (obs_valid === 1'b1 && rdy && !src) begin
                n_checks++;
                if (obs_pc !== m_deliv || obs_data !== m_deliv) begin
                    $display("FAIL rnd_inst@%0d: got pc=%h data=%h expected %h", i, obs_pc, obs_data, m_deliv);
                    n_fail++;
                end
                m_deliv = m_deliv + 32'd4;
                n_del++;
            end
            if (src) begin
                m_pc    = tgt;
                m_deliv = tgt;
            end else if (obs_gnt) begin
                m_pc = m_pc + 32'd4;
            end
            prev_src = src;
        end
        n_checks++;
        if (n_del < 30) begin $display("FAIL rnd_progress: got %0d deliveries expected at least 30", n_del); n_fail++; end
    endtask

    initial begin
        rst_n      = 1'b0;
        pcSrc      = 1'b0;
        target     = '0;
        imemGnt    = 1'b0;
        imemRvalid = 1'b0;
        imemRdata  = '0;
        instReady  = 1'b0;
        clear_obs();
        @(negedge clk);
        test_reset();
        test_stream();
        test_hold();
        test_flush_wait();
        test_flush_grant();
        test_flush_rvalid();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
